// File: rtl/cfa_pkg.sv
// Definitions shared by the CFA demosaic controller and the RGB frame streamer:
// one-hot state encoding and the Q2.8 white-balance gain constants.
package cfa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ISSUE = 3'b010,
    ST_DRAIN = 3'b100
  } state_t;

  localparam int unsigned GAIN_UNITY = 'h100;
  localparam int unsigned ROUND_HALF = 128;
  localparam int unsigned GAIN_SHIFT = 8;

endpackage

// File: rtl/stream_fifo.sv
// Show-ahead synchronous FIFO: rdData presents the head entry whenever empty is low.
// The caller must not push into a full FIFO unless it pops in the same cycle.
module stream_fifo #(
  parameter int DATA_W = 39,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wrData,
  input  logic              pop,
  output logic [DATA_W-1:0] rdData,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr;
  logic              w_rd;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CNT_W'(DEPTH));
  assign count  = r_count;
  assign rdData = r_mem[r_rdPtr];
  assign w_wr   = push;
  assign w_rd   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
      if (w_rd) r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rgb_frame_streamer.sv
// Reads the reconstructed G/R/B channel memories in raster order, applies per-channel
// Q2.8 white-balance gain with rounding and saturation, and streams RGB pixels out.
module rgb_frame_streamer
  import cfa_pkg::*;
#(
  parameter int addressBitWidth = 17,
  parameter int rowBitWidth     = 11,
  parameter int colBitWidth     = 11,
  parameter int dataBitWidth    = 12,
  parameter int gainBitWidth    = 10,
  parameter int fifoDepth       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [rowBitWidth-1:0]     rowMax,
  input  logic [colBitWidth-1:0]     colMax,
  input  logic [gainBitWidth-1:0]    gainR,
  input  logic [gainBitWidth-1:0]    gainG,
  input  logic [gainBitWidth-1:0]    gainB,
  output logic [addressBitWidth-1:0] readAddress,
  output logic                       readEnable,
  input  logic [dataBitWidth-1:0]    greenRead,
  input  logic [dataBitWidth-1:0]    redRead,
  input  logic [dataBitWidth-1:0]    blueRead,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [dataBitWidth-1:0]    outRed,
  output logic [dataBitWidth-1:0]    outGreen,
  output logic [dataBitWidth-1:0]    outBlue,
  output logic                       outSOF,
  output logic                       outEOL,
  output logic                       outEOF,
  output logic                       busy,
  output logic                       done
);

  localparam int PROD_W = dataBitWidth + gainBitWidth + 1;
  localparam int FIFO_W = 3 * dataBitWidth + 3;
  localparam int CNT_W  = $clog2(fifoDepth + 1);
  localparam int CR_W   = CNT_W + 1;
  localparam logic [dataBitWidth-1:0] PIX_MAX = '1;

  function automatic logic [PROD_W-1:0] round_q28(input logic [dataBitWidth-1:0] d,
                                                  input logic [gainBitWidth-1:0] g);
    logic [PROD_W-1:0] p;
    p = PROD_W'(d) * PROD_W'(g) + PROD_W'(ROUND_HALF);
    return p >> GAIN_SHIFT;
  endfunction

  function automatic logic [dataBitWidth-1:0] sat_pix(input logic [PROD_W-1:0] q);
    return (q > PROD_W'(PIX_MAX)) ? PIX_MAX : q[dataBitWidth-1:0];
  endfunction

  state_t                       r_state;
  state_t                       w_nextState;
  logic [rowBitWidth-1:0]       r_rowMax;
  logic [colBitWidth-1:0]       r_colMax;
  logic [2:0][gainBitWidth-1:0] r_gain;
  logic [rowBitWidth-1:0]       r_row;
  logic [colBitWidth-1:0]       r_col;
  logic [addressBitWidth-1:0]   r_addr;
  logic                         r_done;
  logic                         w_issue;
  logic                         w_lastIssue;
  logic                         w_creditOk;
  logic                         w_pop;
  logic                         w_push;
  logic                         w_eofPop;
  logic                         w_outValid;

  logic r_vld_p0, r_sof_p0, r_eol_p0, r_eof_p0;
  logic r_vld_p1, r_sof_p1, r_eol_p1, r_eof_p1;
  logic [2:0][dataBitWidth-1:0] w_readData;
  logic [2:0][dataBitWidth-1:0] w_pix_p1;

  logic [CNT_W-1:0]  w_fifoCount;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_W-1:0] w_fifoIn;
  logic [FIFO_W-1:0] w_fifoOut;

  // Credit counts FIFO entries plus reads still travelling through stages 0 and 1.
  assign w_creditOk = ({1'b0, w_fifoCount} + CR_W'(r_vld_p0) + CR_W'(r_vld_p1))
                      < CR_W'(fifoDepth);

  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    w_lastIssue = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_nextState = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_issue     = w_creditOk;
        w_lastIssue = w_issue && (r_row == r_rowMax) && (r_col == r_colMax);
        if (w_lastIssue) w_nextState = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_eofPop) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= w_eofPop;
      if (r_state == ST_IDLE) begin
        r_row  <= '0;
        r_col  <= '0;
        r_addr <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + 1'b1;
        if (r_col == r_colMax) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rowMax <= '0;
      r_colMax <= '0;
      r_gain   <= {3{gainBitWidth'(GAIN_UNITY)}};
    end else if ((r_state == ST_IDLE) && start) begin
      r_rowMax <= rowMax;
      r_colMax <= colMax;
      r_gain   <= {gainB, gainG, gainR};
    end
  end

  // Stage 0: read issued; tags follow the read while memory data returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p0 <= 1'b0;
      r_sof_p0 <= 1'b0;
      r_eol_p0 <= 1'b0;
      r_eof_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_issue;
      r_sof_p0 <= (r_row == '0) && (r_col == '0);
      r_eol_p0 <= (r_col == r_colMax);
      r_eof_p0 <= (r_col == r_colMax) && (r_row == r_rowMax);
    end
  end

  // Stage 1: capture memory data, apply gain, round and saturate per channel.
  assign w_readData = {blueRead, greenRead, redRead};

  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [dataBitWidth-1:0] r_pix_p1;
    always_ff @(posedge clk) begin
      if (r_vld_p0) r_pix_p1 <= sat_pix(round_q28(w_readData[c], r_gain[c]));
    end
    assign w_pix_p1[c] = r_pix_p1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1 <= 1'b0;
      r_sof_p1 <= 1'b0;
      r_eol_p1 <= 1'b0;
      r_eof_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      r_sof_p1 <= r_sof_p0;
      r_eol_p1 <= r_eol_p0;
      r_eof_p1 <= r_eof_p0;
    end
  end

  // Stage 2: push into the show-ahead output FIFO.
  assign w_fifoIn = {w_pix_p1[0], w_pix_p1[1], w_pix_p1[2], r_sof_p1, r_eol_p1, r_eof_p1};
  assign w_push   = r_vld_p1 & (~w_full | w_pop);

  stream_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (fifoDepth)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (w_push),
    .wrData (w_fifoIn),
    .pop    (w_pop),
    .rdData (w_fifoOut),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_fifoCount)
  );

  assign w_outValid = ~w_empty;
  assign w_pop      = w_outValid & outReady;
  assign w_eofPop   = w_pop & w_fifoOut[0];

  assign outValid    = w_outValid;
  assign outRed      = w_outValid ? w_fifoOut[FIFO_W-1 -: dataBitWidth] : '0;
  assign outGreen    = w_outValid ? w_fifoOut[3+dataBitWidth +: dataBitWidth] : '0;
  assign outBlue     = w_outValid ? w_fifoOut[3 +: dataBitWidth] : '0;
  assign outSOF      = w_outValid & w_fifoOut[2];
  assign outEOL      = w_outValid & w_fifoOut[1];
  assign outEOF      = w_outValid & w_fifoOut[0];
  assign readEnable  = w_issue;
  assign readAddress = r_addr;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_rgb_frame_streamer.sv
// Directed bench for rgb_frame_streamer with a one-cycle-latency channel memory model.
module tb_rgb_frame_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] rowMax = '0;
  logic [10:0] colMax = '0;
  logic [9:0]  gainR = 10'h100;
  logic [9:0]  gainG = 10'h100;
  logic [9:0]  gainB = 10'h100;
  logic [16:0] readAddress;
  logic        readEnable;
  logic [11:0] greenRead = '0;
  logic [11:0] redRead = '0;
  logic [11:0] blueRead = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [11:0] outRed, outGreen, outBlue;
  logic        outSOF, outEOL, outEOF;
  logic        busy, done;

  logic [38:0] outVec;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          gainMode = 1'b0;
  int          rOff = 0, gOff = 0, bOff = 0;

  rgb_frame_streamer dut (
    .clk(clk), .rst(rst), .start(start), .rowMax(rowMax), .colMax(colMax),
    .gainR(gainR), .gainG(gainG), .gainB(gainB),
    .readAddress(readAddress), .readEnable(readEnable),
    .greenRead(greenRead), .redRead(redRead), .blueRead(blueRead),
    .outValid(outValid), .outReady(outReady),
    .outRed(outRed), .outGreen(outGreen), .outBlue(outBlue),
    .outSOF(outSOF), .outEOL(outEOL), .outEOF(outEOF),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (readEnable) begin
      if (gainMode) begin
        redRead   <= 12'd100;
        greenRead <= 12'd3;
        blueRead  <= 12'd4095;
      end else begin
        redRead   <= 12'(32'(readAddress) + rOff);
        greenRead <= 12'(32'(readAddress) + gOff);
        blueRead  <= 12'(32'(readAddress) + bOff);
      end
    end
  end

  assign outVec = {outRed, outGreen, outBlue, outSOF, outEOL, outEOF};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({readEnable, outValid, busy, done, outSOF, outEOL, outEOF}), 64'd0);
    chk({tag, "_addr"}, 64'(readAddress), 64'd0);
    chk({tag, "_pix"}, 64'({outRed, outGreen, outBlue}), 64'd0);
  endtask

  task automatic run_frame(input int nRows, input int nCols, input bit randReady,
                           input bit checkTiming, input int midStartAt);
    int          n, k, issued, popped, startCyc, lastHs;
    bit          gotDone, prevStall;
    logic [39:0] prevVec;
    logic [11:0] eR, eG, eB;
    logic [38:0] expVec;
    n = nRows * nCols;
    k = 0; issued = 0; popped = 0; lastHs = -100;
    gotDone = 1'b0; prevStall = 1'b0; prevVec = '0;
    rowMax = 11'(nRows - 1);
    colMax = 11'(nCols - 1);
    start = 1'b1;
    startCyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("issue_first", 64'({busy, readEnable, readAddress}), 64'({1'b1, 1'b1, 17'd0}));
    for (int c = 0; c < 2000 && !gotDone; c++) begin
      if (done) begin
        gotDone = 1'b1;
        chk("done_after_eof", 64'(cyc), 64'(lastHs + 1));
        chk("pixel_count", 64'(k), 64'(n));
        chk("idle_after_done", 64'({busy, outValid}), 64'd0);
        if (checkTiming) chk("done_latency", 64'(cyc), 64'(startCyc + 4 + n));
      end else begin
        if (prevStall) chk("stall_hold", 64'({outValid, outVec}), 64'(prevVec));
        if (readEnable) issued++;
        chk("credit_in_depth", 64'(issued - popped <= 4), 64'd1);
        outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        if (c == midStartAt) begin
          start  = 1'b1;
          gainR  = 10'h200;
          rowMax = 11'd0;
        end else begin
          start = 1'b0;
        end
        if (outValid && outReady) begin
          if (gainMode) begin
            eR = 12'd150; eG = 12'd2; eB = 12'd4095;
          end else begin
            eR = 12'(k + rOff); eG = 12'(k + gOff); eB = 12'(k + bOff);
          end
          expVec = {eR, eG, eB, k == 0, (k % nCols) == (nCols - 1), k == (n - 1)};
          chk("pixel", 64'(outVec), 64'(expVec));
          if (checkTiming && k == 0) chk("first_latency", 64'(cyc), 64'(startCyc + 4));
          lastHs = cyc;
          k++;
          popped++;
        end
        prevStall = outValid && !outReady;
        prevVec   = {outValid, outVec};
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(gotDone), 64'd1);
  endtask

  initial begin
    #3 rst = 1'b0;
    #1 chk_reset("reset_init");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 4x4 unity gain, identical channels, full throughput
    gainMode = 1'b0; rOff = 0; gOff = 0; bOff = 0;
    gainR = 10'h100; gainG = 10'h100; gainB = 10'h100;
    run_frame(4, 4, 1'b0, 1'b1, -1);

    // gain rounding and saturation
    gainMode = 1'b1;
    gainR = 10'h180; gainG = 10'h080; gainB = 10'h3FF;
    run_frame(2, 2, 1'b0, 1'b1, -1);

    // 16 columns x 8 rows under random backpressure, distinct channels
    gainMode = 1'b0; rOff = 0; gOff = 512; bOff = 1024;
    gainR = 10'h100; gainG = 10'h100; gainB = 10'h100;
    run_frame(8, 16, 1'b1, 1'b0, -1);

    // 1x1 frame
    rOff = 7; gOff = 8; bOff = 9;
    run_frame(1, 1, 1'b0, 1'b1, -1);

    // start, gain and size changes mid-frame are ignored
    rOff = 0; gOff = 0; bOff = 0;
    gainR = 10'h100;
    run_frame(4, 4, 1'b1, 1'b0, 5);

    // reset mid-frame with the FIFO holding data
    gainR = 10'h100;
    rowMax = 11'd3; colMax = 11'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    outReady = 1'b0;
    repeat (6) @(negedge clk);
    chk("midframe_active", 64'({busy, outValid}), 64'b11);
    rst = 1'b0;
    #1 chk_reset("reset_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 64'({busy, readEnable, outValid, done}), 64'd0);

    // full frame after reset release
    run_frame(4, 4, 1'b0, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
